nios_led2_switch_pio: RTL and testbench
=======================================

# nios_led2_switch_pio

Parametrised Avalon-MM input PIO that succeeds the fixed 10-bit switch port of the nios_led2 system. It synchronises and debounces a `WIDTH`-bit external input bus, then captures edges per bit. It raises a maskable interrupt to the Nios II through a four-word register map. It sits on the system interconnect as an `s1` slave and drives one IRQ line.

## Interface
- `WIDTH`, 10, number of input bits (1..32); unused `readdata` bits read 0
- `SYNC_STAGES`, 2, flip-flop synchroniser depth on `in_port` (2..4)
- `DEBOUNCE_CYCLES`, 50000, consecutive stable cycles before a bit is accepted; 0 bypasses the debouncer
- `EDGE_TYPE`, 0, edge that sets capture bits: 0 rising, 1 falling, 2 any
- `clk`  in  1  single system clock, all logic rising-edge
- `reset_n`  in  1  synchronous, active-low reset
- `address`  in  2  word address
- `chipselect`  in  1  slave select
- `write_n`  in  1  active-low write strobe, qualified by `chipselect`
- `writedata`  in  32  write data
- `in_port`  in  WIDTH  asynchronous external inputs (switches)
- `readdata`  out  32  registered read data
- `irq`  out  1  level interrupt, active high

## Operation
- Register map:
  - addr 0 DATA: read-only, debounced value `stable`.
  - addr 1 IRQ_MASK: read/write, WIDTH bits.
  - addr 2 EDGE_CAP: read, write-1-to-clear.
  - addr 3 RAW: read-only, synchroniser output.
- Writes to addr 0 and 3 are ignored. Writes use `writedata[WIDTH-1:0]` only.
- Synchroniser: `SYNC_STAGES` registers per bit. `sync` is the last stage.
- Debouncer, per bit `i`, with counter width `clog2(DEBOUNCE_CYCLES+1)`:
  - If `sync[i] == stable[i]`: counter clears to 0.
  - Otherwise the counter increments. When it reaches `DEBOUNCE_CYCLES`, `stable[i]` takes `sync[i]` on that edge and the counter clears.
  - A glitch shorter than `DEBOUNCE_CYCLES` cycles never reaches `stable`.
  - `DEBOUNCE_CYCLES == 0`: `stable = sync`, and no counters are instantiated.
- Edge detect: `stable_d` is `stable` registered. The edge term is `stable & ~stable_d` (rising), `~stable & stable_d` (falling) or `stable ^ stable_d` (any).
- `EDGE_CAP` bit sets on a detected edge and holds until cleared.
  - A write to addr 2 clears the bits where `writedata` is 1.
  - Set and clear on the same edge: set wins, and the bit stays 1.
- `irq = |(EDGE_CAP & IRQ_MASK)`, driven from registers only, with no combinational path from bus inputs.
- Read mux: every edge, `readdata` loads the word selected by `address`, zero-extended to 32 bits. This is independent of `chipselect`.
- Reset (`reset_n` low at an edge) clears to 0: `readdata`, `IRQ_MASK`, `EDGE_CAP`, `stable`, `stable_d`, synchroniser stages and counters. `irq` is therefore 0.
- Reset mid-debounce discards partial counts. An input held high through reset is accepted as a new rising edge once debounced; this is the defined behaviour.

## Timing
- Read latency is 1: `address` is presented at edge N and `readdata` is valid after edge N.
- Write takes effect at the edge where `chipselect & ~write_n`. A read of the same register at the next edge returns the new value.
- Input path, with `in_port` changing before edge 0:
  - `sync` updates at edge `SYNC_STAGES-1`.
  - `stable` updates at edge `SYNC_STAGES-1+DEBOUNCE_CYCLES`.
  - `EDGE_CAP` and `irq` update one edge later.
  - DATA on `readdata` is valid one edge after `stable` updates, if addressed.
- Mask change: `irq` follows on the edge after the write, with no extra cycles.
- Back-to-back writes on consecutive cycles are all honoured. There is no wait-request.

## Test plan
- Reset and readback (WIDTH=10, DEBOUNCE_CYCLES=4, SYNC_STAGES=2):
  - Stimulus: assert `reset_n`=0 for 2 cycles, then read addr 0..3.
  - Required: all read 0 and `irq`=0. Write `0x3FF` to addr 1 and read it back as `0x3FF`. Write `0xFFFFFFFF` and read back `0x3FF`.
- Debounce accept:
  - Stimulus: drive `in_port` 0→`0x005` before edge 0.
  - Required: RAW reads `0x005` after edge 2. `stable` changes at edge 5. DATA reads `0x005` after edge 6. `EDGE_CAP`=`0x005` after edge 6.
- Glitch reject:
  - Stimulus: pulse `in_port[3]` high for 3 cycles.
  - Required: DATA stays 0, `EDGE_CAP` stays 0, and the counter returns to 0.
- IRQ mask and clear:
  - Setup: mask=`0x001` and `EDGE_CAP`=`0x005`.
  - Required: `irq`=1. Write `0x001` to addr 2 → `irq`=0 next edge, and `EDGE_CAP` reads `0x004`.
- Simultaneous set/clear:
  - Stimulus: a bit-0 edge arrives on the same edge as a W1C write of `0x001`.
  - Required: `EDGE_CAP[0]`=1 afterwards.
- Mid-operation reset and bypass:
  - Stimulus: reset asserted halfway through a debounce count.
  - Required: all state 0 and the count restarts from 0.
  - With `DEBOUNCE_CYCLES`=0 and `EDGE_TYPE`=2, toggling a bit sets `EDGE_CAP` at edge `SYNC_STAGES` on both edges.

Source files
------------

// File: rtl/nios_led2_switch_pio.sv
// Purpose: Avalon-MM input PIO; synchronises, debounces and edge-captures a switch bus, and raises a maskable IRQ.
// Latency: read data 1 cycle after address; input to stable = SYNC_STAGES-1+DEBOUNCE_CYCLES edges, capture/irq one edge later.
// Backpressure: none; no wait-request, so every bus cycle completes, including back-to-back writes.
module nios_led2_switch_pio #(
    parameter int WIDTH           = 10,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int EDGE_TYPE       = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] stable_d;
    logic [WIDTH-1:0] edge_term;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_cap;
    logic [WIDTH-1:0] cap_clr;
    logic [31:0]      rd_word;
    logic             wr_en;

    assign wr_en = chipselect & ~write_n;
    assign sync  = sync_q[SYNC_STAGES-1];

    // Upper write-data bits carry nothing for narrow ports.
    if (WIDTH < 32) begin : g_wd_pad
        logic unused_wd;
        assign unused_wd = &{1'b0, writedata[31:WIDTH]};
    end

    // Multi-stage synchroniser shifting the asynchronous pins into the clock domain.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in_port};
        end
    end

    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
        assign stable = sync;
    end else begin : g_debounce
        localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
        localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
        logic [CW-1:0]    cnt_q [WIDTH];
        logic [WIDTH-1:0] stable_q;

        // Per-bit stability counter; a bit is accepted only after DEBOUNCE_CYCLES consecutive mismatching cycles.
        always_ff @(posedge clk) begin
            if (!reset_n) begin
                stable_q <= '0;
                for (int i = 0; i < WIDTH; i++) begin
                    cnt_q[i] <= '0;
                end
            end else begin
                for (int i = 0; i < WIDTH; i++) begin
                    if (sync[i] == stable_q[i]) begin
                        cnt_q[i] <= '0;
                    end else if (cnt_q[i] == LAST) begin
                        stable_q[i] <= sync[i];
                        cnt_q[i]    <= '0;
                    end else begin
                        cnt_q[i] <= cnt_q[i] + CW'(1);
                    end
                end
            end
        end

        assign stable = stable_q;
    end

    // Delayed copy of the debounced value for edge detection.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stable_d <= '0;
        end else begin
            stable_d <= stable;
        end
    end

    // Select which transition sets capture bits.
    always_comb begin
        edge_term = stable ^ stable_d;
        if (EDGE_TYPE == 0) begin
            edge_term = stable & ~stable_d;
        end else if (EDGE_TYPE == 1) begin
            edge_term = ~stable & stable_d;
        end
    end

    assign cap_clr = (wr_en && address == 2'd2) ? writedata[WIDTH-1:0] : '0;

    // Interrupt mask register, written through address 1.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            irq_mask <= '0;
        end else if (wr_en && address == 2'd1) begin
            irq_mask <= writedata[WIDTH-1:0];
        end
    end

    // Edge capture with write-1-to-clear; a new edge beats a clear in the same cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            edge_cap <= '0;
        end else begin
            edge_cap <= (edge_cap & ~cap_clr) | edge_term;
        end
    end

    // Read word selection, zero-extended to the bus width.
    always_comb begin
        rd_word = '0;
        case (address)
            2'd0:    rd_word[WIDTH-1:0] = stable;
            2'd1:    rd_word[WIDTH-1:0] = irq_mask;
            2'd2:    rd_word[WIDTH-1:0] = edge_cap;
            default: rd_word[WIDTH-1:0] = sync;
        endcase
    end

    // Registered read data, loaded every cycle regardless of chipselect.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            readdata <= rd_word;
        end
    end

    assign irq = |(edge_cap & irq_mask);

endmodule

// File: tb/tb_nios_led2_switch_pio.sv
module tb_nios_led2_switch_pio;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [9:0]  in_port;
    logic [31:0] readdata;
    logic        irq;
    logic [9:0]  in_port_b;
    logic [31:0] readdata_b;
    logic        irq_b;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] rv;

    always #5 clk = ~clk;

    nios_led2_switch_pio #(
        .WIDTH(10), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(0)
    ) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(readdata), .irq(irq)
    );

    nios_led2_switch_pio #(
        .WIDTH(10), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(2)
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port_b),
        .readdata(readdata_b), .irq(irq_b)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    // Advance past the next rising edge; outputs are sampled 1 ns after it.
    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] v);
        address = a;
        tick();
        v = readdata;
    endtask

    initial begin
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = '0;
        in_port_b  = '0;

        // Reset and readback
        tick(2);
        chk("reset_readdata", readdata, 32'h0);
        chk("reset_irq", {31'b0, irq}, 32'h0);
        reset_n = 1'b1;
        for (int a = 0; a < 4; a++) begin
            bus_read(a[1:0], rv);
            chk($sformatf("reset_read_addr%0d", a), rv, 32'h0);
        end
        bus_write(2'd1, 32'h3FF);
        bus_read(2'd1, rv);
        chk("mask_rw_3ff", rv, 32'h3FF);
        bus_write(2'd1, 32'hFFFF_FFFF);
        bus_read(2'd1, rv);
        chk("mask_rw_truncate", rv, 32'h3FF);
        bus_write(2'd0, 32'h0000_00FF);
        bus_read(2'd0, rv);
        chk("data_write_ignored", rv, 32'h0);
        bus_write(2'd1, 32'h0);

        // Debounce accept: in_port changes before edge 0
        address = 2'd3;
        in_port = 10'h005;
        tick(2);
        chk("raw_after_edge1", readdata, 32'h0);
        tick();
        chk("raw_after_edge2", readdata, 32'h005);
        address = 2'd0;
        tick(3);
        chk("data_after_edge5", readdata, 32'h0);
        tick();
        chk("data_after_edge6", readdata, 32'h005);
        chk("irq_masked_off", {31'b0, irq}, 32'h0);
        bus_read(2'd2, rv);
        chk("edgecap_accept", rv, 32'h005);

        // Glitch reject: two 3-cycle pulses on bit 3, the second proves the count cleared
        in_port = 10'h00D;
        tick(3);
        in_port = 10'h005;
        tick(2);
        in_port = 10'h00D;
        tick(3);
        in_port = 10'h005;
        tick(8);
        bus_read(2'd0, rv);
        chk("glitch_data", rv, 32'h005);
        bus_read(2'd2, rv);
        chk("glitch_edgecap", rv, 32'h005);

        // IRQ mask and clear
        bus_write(2'd1, 32'h001);
        chk("irq_after_mask", {31'b0, irq}, 32'h1);
        bus_write(2'd2, 32'h001);
        chk("irq_after_clear", {31'b0, irq}, 32'h0);
        bus_read(2'd2, rv);
        chk("edgecap_after_clear", rv, 32'h004);

        // Simultaneous set/clear on bit 0
        in_port = 10'h004;
        tick(8);
        bus_read(2'd2, rv);
        chk("falling_not_captured", rv, 32'h004);
        in_port = 10'h005;
        tick(6);
        bus_write(2'd2, 32'h001);
        chk("irq_set_wins", {31'b0, irq}, 32'h1);
        bus_read(2'd2, rv);
        chk("edgecap_set_wins", rv, 32'h005);
        bus_write(2'd2, 32'h001);
        bus_read(2'd2, rv);
        chk("edgecap_later_clear", rv, 32'h004);

        // Mid-debounce reset: bit 1 rises, reset lands at count 2
        in_port = 10'h007;
        tick(4);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        address = 2'd0;
        tick();
        chk("midreset_data", readdata, 32'h0);
        chk("midreset_irq", {31'b0, irq}, 32'h0);
        tick(5);
        chk("midreset_data_edge6", readdata, 32'h0);
        tick();
        chk("midreset_data_edge7", readdata, 32'h007);
        bus_read(2'd1, rv);
        chk("midreset_mask", rv, 32'h0);
        bus_read(2'd2, rv);
        chk("midreset_edgecap", rv, 32'h007);

        // Bypass debouncer, any-edge capture
        bus_write(2'd1, 32'h001);
        bus_write(2'd2, 32'h3FF);
        chk("bypass_irq_idle", {31'b0, irq_b}, 32'h0);
        in_port_b = 10'h001;
        tick(2);
        chk("bypass_rise_edge1", {31'b0, irq_b}, 32'h0);
        tick();
        chk("bypass_rise_edge2", {31'b0, irq_b}, 32'h1);
        bus_write(2'd2, 32'h001);
        chk("bypass_cleared", {31'b0, irq_b}, 32'h0);
        in_port_b = 10'h000;
        tick(2);
        chk("bypass_fall_edge1", {31'b0, irq_b}, 32'h0);
        tick();
        chk("bypass_fall_edge2", {31'b0, irq_b}, 32'h1);
        address = 2'd2;
        tick();
        chk("bypass_edgecap", readdata_b, 32'h001);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
